// File: rtl/tile_pix_pkg.sv
// Shared constants and the nibble-order reversal used by the tile pixel serializer.
// A packed ROM row holds PIX_ROW pixels of PIX_BITS each, with pixel 0 in the top nibble.
package tile_pix_pkg;

    localparam int PIX_BITS = 4;
    localparam int PIX_ROW  = 8;
    localparam int ROM_W    = PIX_BITS * PIX_ROW;

    localparam logic [PIX_BITS-1:0] PIX_TRANSPARENT = '0;

    // Mirror a row: pixel 0 moves from the top nibble to the bottom nibble.
    function automatic logic [ROM_W-1:0] nib_rev(input logic [ROM_W-1:0] row);
        logic [ROM_W-1:0] r;
        r = '0;
        for (int n = 0; n < PIX_ROW; n++)
            r[n*PIX_BITS +: PIX_BITS] = row[(PIX_ROW-1-n)*PIX_BITS +: PIX_BITS];
        return r;
    endfunction

endpackage

// File: rtl/pix_row_flip.sv
// Combinational horizontal flip of one packed tile row, selected per row.
module pix_row_flip
    import tile_pix_pkg::*;
(
    input  logic             flip,
    input  logic [ROM_W-1:0] row,
    output logic [ROM_W-1:0] row_out
);

    assign row_out = flip ? nib_rev(row) : row;

endmodule

// File: rtl/tile_pix_shifter.sv
// Per-layer tile pixel serializer: double-buffers one packed row plus its colour code
// and shifts one pixel per CE, with horizontal flip and 0-7 pixel fine scroll.
module tile_pix_shifter #(
    parameter int PIX_BITS = tile_pix_pkg::PIX_BITS,
    parameter int PIX_ROW  = tile_pix_pkg::PIX_ROW,
    parameter int COL_W    = 8
) (
    input  logic                        CK,
    input  logic                        RST,
    input  logic                        CE,
    input  logic                        LOAD,
    input  logic [PIX_BITS*PIX_ROW-1:0] ROM_D,
    input  logic [COL_W-1:0]            COL_IN,
    input  logic                        FLIPX,
    input  logic [2:0]                  FINE,
    output logic [PIX_BITS-1:0]         PIX,
    output logic [COL_W-1:0]            COL,
    output logic                        OPAQUE,
    output logic                        OVR
);

    import tile_pix_pkg::*;

    localparam int RW = PIX_BITS * PIX_ROW;

    logic [RW-1:0]    rom_flip;
    logic [RW-1:0]    pend_d;
    logic [COL_W-1:0] pend_c;
    logic             pend_v;
    logic [RW-1:0]    sh;
    logic [2:0]       cnt;
    logic [2:0]       fine_r;
    logic             xfer;

    pix_row_flip u_flip (
        .flip    (FLIPX),
        .row     (ROM_D),
        .row_out (rom_flip)
    );

    // The row boundary sits wherever the free-running pixel counter meets the latched scroll.
    assign xfer = CE && (cnt == fine_r);

    always_ff @(posedge CK) begin
        if (RST) begin
            pend_d <= '0;
            pend_c <= '0;
            pend_v <= 1'b0;
            sh     <= '0;
            COL    <= '0;
            cnt    <= '0;
            fine_r <= '0;
            OVR    <= 1'b0;
        end else if (CE) begin
            cnt <= cnt + 1'b1;

            if (xfer) begin
                sh     <= pend_v ? pend_d : '0;
                COL    <= pend_v ? pend_c : '0;
                fine_r <= FINE;
            end else begin
                sh <= {sh[RW-PIX_BITS-1:0], PIX_TRANSPARENT};
            end

            // On a coincident transfer the shifter already took the old row, so the new one stays pending.
            if (LOAD) begin
                pend_d <= rom_flip;
                pend_c <= COL_IN;
                pend_v <= 1'b1;
                if (pend_v && !xfer)
                    OVR <= 1'b1;
            end else if (xfer) begin
                pend_v <= 1'b0;
            end
        end
    end

    assign PIX    = sh[RW-1 -: PIX_BITS];
    assign OPAQUE = |sh[RW-1 -: PIX_BITS];

endmodule

// File: tb/tb_tile_pix_shifter.sv
// Bench for tile_pix_shifter: directed rows plus randomized traffic against a queue-based pixel model.
module tb_tile_pix_shifter;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        load = 1'b0;
    logic [31:0] rom_d = '0;
    logic [7:0]  col_in = '0;
    logic        flipx = 1'b0;
    logic [2:0]  fine = '0;
    logic [3:0]  pix;
    logic [7:0]  col;
    logic        opaque;
    logic        ovr;

    int n_cmp = 0;
    int n_bad = 0;

    tile_pix_shifter dut (
        .CK     (ck),
        .RST    (rst),
        .CE     (ce),
        .LOAD   (load),
        .ROM_D  (rom_d),
        .COL_IN (col_in),
        .FLIPX  (flipx),
        .FINE   (fine),
        .PIX    (pix),
        .COL    (col),
        .OPAQUE (opaque),
        .OVR    (ovr)
    );

    always #5 ck = ~ck;

    // Model: the visible row is a queue of pixels consumed from the front, one per non-transfer CE.
    logic [3:0] m_q[$];
    logic [3:0] m_pend[8];
    logic [7:0] m_pc;
    logic       m_pv;
    logic [7:0] m_col;
    logic       m_ovr;
    int         m_cnt;
    int         m_fine;
    logic [2:0] cur_fine;

    function automatic logic [3:0] row_pix(input logic [31:0] d, input logic f, input int n);
        logic [31:0] v;
        v = d;
        return f ? v[4*n +: 4] : v[31-4*n -: 4];
    endfunction

    function automatic logic [3:0] exp_pix();
        return (m_q.size() > 0) ? m_q[0] : 4'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit x;
        if (rst) begin
            m_q.delete();
            for (int n = 0; n < 8; n++) m_pend[n] = 4'h0;
            m_pc = '0; m_pv = 1'b0; m_col = '0; m_ovr = 1'b0; m_cnt = 0; m_fine = 0;
        end else if (ce) begin
            x = (m_cnt == m_fine);
            if (x) begin
                m_q.delete();
                for (int n = 0; n < 8; n++) m_q.push_back(m_pv ? m_pend[n] : 4'h0);
                m_col  = m_pv ? m_pc : 8'h00;
                m_fine = int'(fine);
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_front());
            end
            if (load) begin
                if (m_pv && !x) m_ovr = 1'b1;
                for (int n = 0; n < 8; n++) m_pend[n] = row_pix(rom_d, flipx, n);
                m_pc = col_in;
                m_pv = 1'b1;
            end else if (x) begin
                m_pv = 1'b0;
            end
            m_cnt = (m_cnt + 1) % 8;
        end
    endtask

    task automatic step(input logic r, input logic c, input logic l, input logic [31:0] d,
                        input logic [7:0] cc, input logic f, input logic [2:0] fn);
        rst = r; ce = c; load = l; rom_d = d; col_in = cc; flipx = f; fine = fn;
        @(posedge ck);
        model_edge();
        #1;
        chk("pix", {28'h0, pix}, {28'h0, exp_pix()});
        chk("col", {24'h0, col}, {24'h0, m_col});
        chk("opaque", {31'h0, opaque}, {31'h0, exp_pix() != 4'h0});
        chk("ovr", {31'h0, ovr}, {31'h0, m_ovr});
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0, cur_fine);
    endtask

    task automatic do_reset();
        cur_fine = 3'd0;
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1, 3'd5);
        step(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 3'd0);
    endtask

    task automatic wait_cnt7();
        int g = 0;
        while (m_cnt != 7 && g < 16) begin
            idle();
            g++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] mask;
        logic        c;
        logic        l;

        // Reset state
        do_reset();
        chk("rst_pix", {28'h0, pix}, 32'h0);
        chk("rst_col", {24'h0, col}, 32'h0);
        chk("rst_opaque", {31'h0, opaque}, 32'h0);
        chk("rst_ovr", {31'h0, ovr}, 32'h0);

        // Plain row, then flipped row, then a sparse row
        wait_cnt7();
        step(1'b0, 1'b1, 1'b1, 32'h12345678, 8'hA5, 1'b0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            idle();
            chk("seq_plain", {28'h0, pix}, k + 1);
            chk("seq_col", {24'h0, col}, 32'hA5);
            chk("seq_opaque", {31'h0, opaque}, 32'h1);
        end
        wait_cnt7();
        step(1'b0, 1'b1, 1'b1, 32'h12345678, 8'h3C, 1'b1, 3'd0);
        for (int k = 0; k < 8; k++) begin
            idle();
            chk("seq_flip", {28'h0, pix}, 8 - k);
            chk("seq_flip_col", {24'h0, col}, 32'h3C);
        end
        wait_cnt7();
        step(1'b0, 1'b1, 1'b1, 32'h10203040, 8'h11, 1'b0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            idle();
            chk("seq_sparse_opaque", {31'h0, opaque}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end

        // Fine scroll change 0 -> 3 with a row loaded every 8 CE
        cur_fine = 3'd3;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 8; j++) begin
                if (j == 0) step(1'b0, 1'b1, 1'b1, $urandom(), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), cur_fine);
                else idle();
            end
        end

        // Overrun: two loads with no transfer between, then an underrun row
        do_reset();
        idle();
        step(1'b0, 1'b1, 1'b1, 32'h11111111, 8'h22, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 32'h9ABCDEF1, 8'h77, 1'b0, 3'd0);
        chk("ovr_set", {31'h0, ovr}, 32'h1);
        for (int k = 0; k < 6; k++) idle();
        chk("ovr_row_pix", {28'h0, pix}, 32'h9);
        chk("ovr_row_col", {24'h0, col}, 32'h77);
        for (int k = 0; k < 8; k++) idle();
        chk("underrun_pix", {28'h0, pix}, 32'h0);
        chk("underrun_col", {24'h0, col}, 32'h0);
        chk("ovr_held", {31'h0, ovr}, 32'h1);
        for (int k = 0; k < 7; k++) idle();

        // Load coincident with every transfer, CE one cycle in four
        do_reset();
        for (int i = 0; i < 160; i++) begin
            c = (i % 4 == 0);
            l = c && (m_cnt == m_fine);
            step(1'b0, c, l, $urandom(), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'd0);
        end
        chk("coincident_no_ovr", {31'h0, ovr}, 32'h0);

        // Reset in the middle of a row
        do_reset();
        wait_cnt7();
        step(1'b0, 1'b1, 1'b1, 32'h12345678, 8'h5A, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) idle();
        chk("midrow_pix", {28'h0, pix}, 32'h5);
        step(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 8'hFF, 1'b0, 3'd0);
        chk("midrow_rst_pix", {28'h0, pix}, 32'h0);
        chk("midrow_rst_col", {24'h0, col}, 32'h0);
        chk("midrow_rst_opaque", {31'h0, opaque}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h2468ACE1, 8'hC3, 1'b0, 3'd0);
        for (int k = 0; k < 7; k++) idle();
        chk("after_rst_pre", {28'h0, pix}, 32'h0);
        idle();
        chk("after_rst_pix", {28'h0, pix}, 32'h2);
        chk("after_rst_col", {24'h0, col}, 32'hC3);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            mask = '0;
            for (int n = 0; n < 8; n++)
                if ($urandom_range(0, 2) != 0) mask[4*n +: 4] = 4'hF;
            d = $urandom() & mask;
            if ($urandom_range(0, 39) == 0) cur_fine = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 5) == 0), d, 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), cur_fine);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
